// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divide sequencer.
//   - state_t     : controller states
//   - DIV_WIDTH   : default datapath width
//   - SEL_LO/HI   : HI/LO select encodings for rd_sel / wr_sel
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_EXC    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO storage.
// Ports:
//   clock, reset             : clock and synchronous active-high reset
//   commit, commit_hi/lo     : divider result write (wins over wr_*)
//   wr_en, wr_sel, wr_data   : mthi/mtlo write port (already qualified by caller)
//   rd_sel, rd_data          : combinational read mux
//   hi, lo                   : register contents
module hilo_regs
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit,
    input  logic [WIDTH-1:0] commit_hi,
    input  logic [WIDTH-1:0] commit_lo,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = commit_hi;
            lo_d = commit_lo;
        end else if (wr_en) begin
            if (wr_sel == SEL_HI) hi_d = wr_data;
            else                  lo_d = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (rd_sel == SEL_HI) ? hi_q : lo_q;

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: control between the CPU and an external divider.
// Launches the divider with a one-cycle div_start pulse and held operands,
// rejects a zero divisor without launching, guards the wait with a
// watchdog, and commits the result into HI/LO.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   op_start, op_a, op_b             : divide request (taken only in IDLE)
//   div_start, div_a, div_b          : divider launch and operands
//   div_lo, div_hi, div_done, div_zero : divider result/status
//   busy, done, div0_exc, timeout_err : status to the pipeline
//   rd_sel, rd_data                  : mfhi/mflo read
//   wr_en, wr_sel, wr_data           : mthi/mtlo write (IDLE only)
//   hi, lo                           : architectural HI/LO
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_lo,
    input  logic [WIDTH-1:0] div_hi,
    input  logic             div_done,
    input  logic             div_zero,
    output logic             busy,
    output logic             done,
    output logic             div0_exc,
    output logic             timeout_err,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             tout_q, tout_d;
    logic             commit;
    logic             wr_en_idle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        tout_d  = tout_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_start) begin
                    if (op_b != '0) begin
                        state_d = S_LAUNCH;
                        a_d     = op_a;
                        b_d     = op_b;
                    end else begin
                        state_d = S_EXC;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A zero report from the divider overrides a simultaneous done.
                if (div_zero) begin
                    state_d = S_EXC;
                end else if (div_done) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXC:   state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tout_q  <= tout_d;
        end
    end

    assign div_start   = (state_q == S_LAUNCH);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign div0_exc    = (state_q == S_EXC);
    assign timeout_err = tout_q;
    assign div_a       = a_q;
    assign div_b       = b_q;

    // Architectural writes are only legal while no division is in flight.
    assign wr_en_idle = wr_en && (state_q == S_IDLE);

    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clock     (clock),
        .reset     (reset),
        .commit    (commit),
        .commit_hi (div_hi),
        .commit_lo (div_lo),
        .wr_en     (wr_en_idle),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, op_start, div_done, div_zero, rd_sel, wr_en, wr_sel;
    logic [W-1:0] op_a, op_b, div_lo, div_hi, wr_data;
    logic         div_start, busy, done, div0_exc, timeout_err;
    logic [W-1:0] div_a, div_b, rd_data, hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_sequencer #(.WIDTH(W), .TIMEOUT(40)) dut (
        .clock(clock), .reset(reset), .op_start(op_start), .op_a(op_a), .op_b(op_b),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_lo(div_lo), .div_hi(div_hi), .div_done(div_done), .div_zero(div_zero),
        .busy(busy), .done(done), .div0_exc(div0_exc), .timeout_err(timeout_err),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .hi(hi), .lo(lo)
    );

    // Advance one clock edge and sample 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_start = 0; op_a = 0; op_b = 0; div_done = 0; div_zero = 0;
        div_lo = 0; div_hi = 0; rd_sel = 0; wr_en = 0; wr_sel = 0; wr_data = 0;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if ({div_start, busy, done, div0_exc, timeout_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {div_start, busy, done, div0_exc, timeout_err});
        end
        checks++;
        if (hi !== 0 || lo !== 0 || div_a !== 0 || div_b !== 0) begin
            errors++; $display("FAIL reset_regs hi=%0h lo=%0h a=%0h b=%0h exp all 0", hi, lo, div_a, div_b);
        end
        checks++;
        if (rd_data !== 0) begin errors++; $display("FAIL reset_rd_lo got=%0h exp=0", rd_data); end
        rd_sel = 1; #1;
        checks++;
        if (rd_data !== 0) begin errors++; $display("FAIL reset_rd_hi got=%0h exp=0", rd_data); end
        rd_sel = 0;
        $display("reset: flags and registers checked");
    endtask

    // 100 / 7 with the result returned 32 WAIT cycles in (sampled in cycle 34).
    task automatic test_divide();
        int e0 = errors;
        op_start = 1; op_a = 100; op_b = 7;
        for (int c = 1; c <= 36; c++) begin
            step();
            op_start = 0;
            div_done = 0;
            checks++;
            if (div_start !== (c == 1)) begin errors++; $display("FAIL div_start c=%0d got=%b exp=%b", c, div_start, (c == 1)); end
            checks++;
            if (busy !== (c <= 35)) begin errors++; $display("FAIL busy c=%0d got=%b exp=%b", c, busy, (c <= 35)); end
            checks++;
            if (done !== (c == 35)) begin errors++; $display("FAIL done c=%0d got=%b exp=%b", c, done, (c == 35)); end
            if (c == 2) begin
                checks++;
                if (div_a !== 100 || div_b !== 7) begin errors++; $display("FAIL operands got=%0d/%0d exp=100/7", div_a, div_b); end
            end
            if (c == 34) begin div_done = 1; div_lo = 14; div_hi = 2; end
            if (c == 33) begin
                checks++;
                if (lo !== 0 || hi !== 0) begin errors++; $display("FAIL early_commit lo=%0d hi=%0d exp=0/0", lo, hi); end
            end
            if (c == 35) begin
                checks++;
                if (lo !== 14 || hi !== 2) begin errors++; $display("FAIL commit lo=%0d hi=%0d exp=14/2", lo, hi); end
                rd_sel = 1; #1;
                checks++;
                if (rd_data !== 2) begin errors++; $display("FAIL rd_hi got=%0d exp=2", rd_data); end
                rd_sel = 0; #1;
                checks++;
                if (rd_data !== 14) begin errors++; $display("FAIL rd_lo got=%0d exp=14", rd_data); end
            end
        end
        $display("divide 100/7: lo=%0d hi=%0d errors=%0d", lo, hi, errors - e0);
    endtask

    task automatic test_div_by_zero();
        wr_en = 1; wr_sel = 1; wr_data = 5; step();
        wr_sel = 0; wr_data = 9; step();
        wr_en = 0;
        checks++;
        if (hi !== 5 || lo !== 9) begin errors++; $display("FAIL mthi_mtlo hi=%0d lo=%0d exp=5/9", hi, lo); end
        op_start = 1; op_a = 33; op_b = 0;
        step();
        op_start = 0;
        checks++;
        if ({div0_exc, busy, div_start} !== 3'b110) begin
            errors++; $display("FAIL div0_c1 exc/busy/start=%b exp=110", {div0_exc, busy, div_start});
        end
        step();
        checks++;
        if ({div0_exc, busy, div_start} !== 3'b000) begin
            errors++; $display("FAIL div0_c2 exc/busy/start=%b exp=000", {div0_exc, busy, div_start});
        end
        checks++;
        if (hi !== 5 || lo !== 9) begin errors++; $display("FAIL div0_hilo hi=%0d lo=%0d exp=5/9", hi, lo); end
        $display("divide-by-zero from IDLE: hi=%0d lo=%0d", hi, lo);
    endtask

    task automatic test_zero_priority();
        op_start = 1; op_a = 50; op_b = 5;
        step(); op_start = 0;          // LAUNCH
        step();                        // first WAIT
        div_zero = 1; div_done = 1; div_lo = 77; div_hi = 88;
        step();
        div_zero = 0; div_done = 0;
        checks++;
        if (div0_exc !== 1 || done !== 0) begin errors++; $display("FAIL zero_prio exc=%b done=%b exp=1/0", div0_exc, done); end
        checks++;
        if (hi !== 5 || lo !== 9) begin errors++; $display("FAIL zero_prio_hilo hi=%0d lo=%0d exp=5/9", hi, lo); end
        step();
        checks++;
        if (busy !== 0 || div0_exc !== 0) begin errors++; $display("FAIL zero_prio_idle busy=%b exc=%b exp=0/0", busy, div0_exc); end
        $display("div_zero with div_done in WAIT: exception taken, no commit");
    endtask

    task automatic test_timeout();
        op_start = 1; op_a = 1; op_b = 1;
        for (int c = 1; c <= 42; c++) begin
            step();
            op_start = 0;
            checks++;
            if (timeout_err !== (c >= 42) || busy !== (c <= 41)) begin
                errors++; $display("FAIL timeout c=%0d err=%b busy=%b exp=%b/%b", c, timeout_err, busy, (c >= 42), (c <= 41));
            end
        end
        // A new request still succeeds; the sticky flag remains.
        op_start = 1; op_a = 20; op_b = 4;
        step(); op_start = 0;
        step();
        div_done = 1; div_lo = 5; div_hi = 0;
        step();
        div_done = 0;
        checks++;
        if (done !== 1 || lo !== 5 || hi !== 0) begin errors++; $display("FAIL after_timeout done=%b lo=%0d hi=%0d exp=1/5/0", done, lo, hi); end
        checks++;
        if (timeout_err !== 1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
        step();
        $display("timeout: flag sticky, 20/4 -> lo=%0d hi=%0d", lo, hi);
    endtask

    task automatic test_write_and_reset();
        op_start = 1; op_a = 100; op_b = 7;
        step(); op_start = 0;
        wr_en = 1; wr_sel = 1; wr_data = 32'hDEAD;
        step();
        wr_en = 0;
        checks++;
        if (hi !== 0) begin errors++; $display("FAIL wr_busy hi=%0h exp=0", hi); end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if ({div_start, busy, done, div0_exc, timeout_err} !== 5'b0 || hi !== 0 || lo !== 0 || div_a !== 0 || div_b !== 0) begin
            errors++; $display("FAIL mid_reset flags=%b hi=%0h lo=%0h a=%0h b=%0h exp all 0",
                {div_start, busy, done, div0_exc, timeout_err}, hi, lo, div_a, div_b);
        end
        div_done = 1; div_lo = 14; div_hi = 2;
        step();
        div_done = 0;
        checks++;
        if (busy !== 0 || done !== 0 || hi !== 0 || lo !== 0) begin
            errors++; $display("FAIL late_done busy=%b done=%b hi=%0h lo=%0h exp 0", busy, done, hi, lo);
        end
        wr_en = 1; wr_sel = 1; wr_data = 32'hDEAD;
        step();
        wr_en = 0;
        checks++;
        if (hi !== 32'hDEAD || lo !== 0) begin errors++; $display("FAIL wr_idle hi=%0h lo=%0h exp=dead/0", hi, lo); end
        $display("write gating and mid-operation reset: hi=%0h", hi);
    endtask

    task automatic test_write_with_start();
        wr_en = 1; wr_sel = 0; wr_data = 123;
        op_start = 1; op_a = 9; op_b = 3;
        step();
        wr_en = 0; op_start = 0;
        checks++;
        if (lo !== 123 || div_start !== 1) begin errors++; $display("FAIL wr_start lo=%0d start=%b exp=123/1", lo, div_start); end
        step();
        div_done = 1; div_lo = 3; div_hi = 0;
        step();
        div_done = 0;
        checks++;
        if (lo !== 3 || hi !== 0) begin errors++; $display("FAIL wr_start_commit lo=%0d hi=%0h exp=3/0", lo, hi); end
        step();
        $display("write and start together: lo=%0d hi=%0h", lo, hi);
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_by_zero();
        test_zero_priority();
        test_timeout();
        test_write_and_reset();
        test_write_with_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller between the CPU control unit and the divider. Accepts a divide request, rejects divide-by-zero locally, and launches the divider with a one-cycle start pulse and stable operands. It waits for completion with a watchdog and commits the quotient and remainder into the architectural HI/LO registers. It also serves mfhi/mflo reads and mthi/mtlo writes, and stalls the pipeline while a division is in flight.

## Interface
- `WIDTH`, 32, datapath width
- `TIMEOUT`, 40, max cycles spent in WAIT before aborting (must be ≥ 2)

- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `op_start` in 1: divide request, sampled only in IDLE
- `op_a` / `op_b` in WIDTH: dividend (RS) / divisor (RT), sampled with `op_start`
- `div_start` out 1: one-cycle launch pulse to the divider
- `div_a` / `div_b` out WIDTH: registered operands, stable from LAUNCH until return to IDLE
- `div_lo` / `div_hi` in WIDTH: divider quotient / remainder
- `div_done` in 1: divider result valid
- `div_zero` in 1: divider reports divide-by-zero
- `busy` out 1: stall, high whenever state ≠ IDLE
- `done` out 1: one-cycle pulse in the cycle after commit
- `div0_exc` out 1: one-cycle divide-by-zero exception pulse
- `timeout_err` out 1: sticky until reset
- `rd_sel` in 1: 0 = LO, 1 = HI
- `rd_data` out WIDTH: combinational HI/LO read
- `wr_en` in 1, `wr_sel` in 1, `wr_data` in WIDTH: mtlo (sel 0) / mthi (sel 1)
- `hi` / `lo` out WIDTH: architectural HI/LO

## Operation
- States and transitions:
  - IDLE → LAUNCH on `op_start` with `op_b ≠ 0`; operands are latched into `div_a`/`div_b`.
  - IDLE → EXC on `op_start` with `op_b = 0`; no launch, HI/LO unchanged.
  - LAUNCH → WAIT; `div_start` = 1 in LAUNCH only.
  - WAIT → EXC if `div_zero` = 1; this takes priority over `div_done`.
  - WAIT → DONE if `div_done` = 1; `hi` ← `div_hi` and `lo` ← `div_lo` on that edge.
  - WAIT → IDLE when the wait counter reaches TIMEOUT−1 without done/zero; sets `timeout_err`, HI/LO unchanged.
  - EXC → IDLE with `div0_exc` = 1 during EXC.
  - DONE → IDLE with `done` = 1 during DONE.
- Wait counter:
  - cleared on entry to WAIT;
  - increments each WAIT cycle;
  - width is clog2(TIMEOUT).
- `op_start` outside IDLE is ignored. Requests are not queued.
- `wr_en` is honoured only in IDLE and ignored otherwise.
- `wr_en` and `op_start` in the same IDLE cycle: the write is applied and the division launches. The later commit overwrites both registers.
- No sign handling here; signed semantics belong to the divider.

## Timing
- Reset state: IDLE. Counter 0. `hi`, `lo`, `div_a`, `div_b` = 0. `div_start`, `busy`, `done`, `div0_exc`, `timeout_err` = 0.
- `rd_data` reflects reset HI/LO, i.e. 0.
- Request at edge 0 (IDLE, valid divisor):
  - cycle 1: LAUNCH, `div_start` = 1, `busy` = 1;
  - cycle 2: first WAIT cycle;
  - `div_done` sampled in WAIT cycle 2+k → DONE in cycle 3+k;
  - new HI/LO visible from cycle 3+k, IDLE in cycle 4+k.
- Divide-by-zero from IDLE: `div0_exc` and `busy` high in cycle 1 only; IDLE in cycle 2.
- Timeout: `timeout_err` rises after exactly TIMEOUT WAIT cycles; IDLE in the same cycle.
- `rd_data` shows a committed value in the first cycle after the commit edge. There is no bypass from `div_lo`/`div_hi`.
- Reset mid-operation:
  - returns to IDLE on the next edge;
  - `div_start` is deasserted;
  - HI/LO are cleared;
  - the pending result is discarded.

## Structure
- Shared package `div_pkg`: state enum (IDLE, LAUNCH, WAIT, EXC, DONE), `WIDTH` default, HI/LO select encodings.
- Sub-module `hilo_regs`: HI/LO storage, commit and mthi/mtlo write ports with commit priority, and the `rd_sel` read mux.
- Top level holds the FSM, operand registers and watchdog.

## Test plan
- 100 / 7, model returns lo=14, hi=2 after 32 cycles:
  - `div_start` pulses once in cycle 1;
  - `busy` is high for cycles 1–35;
  - `done` in cycle 35, `lo` = 14, `hi` = 2;
  - `rd_sel` = 1 gives 2.
- `op_b` = 0 with HI = 5, LO = 9:
  - `div0_exc` pulse in cycle 1 and no `div_start`;
  - HI/LO stay 5/9.
- Model asserts `div_zero` and `div_done` together in WAIT: EXC taken, `div0_exc` pulses, no commit.
- Model never completes, TIMEOUT = 40:
  - `timeout_err` rises after 40 WAIT cycles and stays set;
  - a new request with `op_a` = 20, `op_b` = 4 and model result lo = 5, hi = 0 still succeeds.
- `wr_en` (sel 1, data 0xDEAD) while `busy`: ignored. The same write in IDLE: `hi` = 0xDEAD next cycle.
- `reset` asserted in WAIT: next cycle IDLE, all outputs 0; a late `div_done` is ignored.
